// File: rtl/pc_redirect_unit.sv
// pc_redirect_unit
//   Fetch PC register and next-PC selection for the pipelined MIPS core.
//   Evaluates branches (beq/bne/blez/bgtz/bltz/bgez) and jumps (j/jal, jr/jalr)
//   from decode. A redirect that arrives while fetch is stalled is held and
//   applied on the first unstalled edge.
//
// Optional feature macro: PC_EXC_EN (adds exception entry and eret return).
//
// Ports:
//   clk, reset       clock, synchronous active-high reset
//   fetch_stall      hold the PC this cycle
//   br_type          000 none, 001 beq, 010 bne, 011 blez, 100 bgtz,
//                    101 bltz, 110 bgez, 111 reserved (no branch)
//   jump, jump_reg   j/jal and jr/jalr in decode
//   dec_pc           PC of the decode-stage instruction
//   rs_val, rt_val   forwarded operands
//   imm16, imm26     branch offset, jump index
//   exc_req, eret,   (PC_EXC_EN only) exception entry, return, return address
//   epc
//   pc               registered fetch PC
//   pc_plus4         pc + 4
//   link_addr        dec_pc + 8 (return address past the delay slot)
//   taken            decode instruction redirects fetch this cycle
//   pend_valid       a redirect is buffered
module pc_redirect_unit #(
    parameter int unsigned WIDTH    = 32,
    parameter logic [31:0] RESET_PC = 32'h0000_3000
`ifdef PC_EXC_EN
    ,
    parameter logic [31:0] EXC_VECTOR = 32'h0000_4180
`endif
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             fetch_stall,
    input  logic [2:0]       br_type,
    input  logic             jump,
    input  logic             jump_reg,
    input  logic [WIDTH-1:0] dec_pc,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    input  logic [15:0]      imm16,
    input  logic [25:0]      imm26,
`ifdef PC_EXC_EN
    input  logic             exc_req,
    input  logic             eret,
    input  logic [WIDTH-1:0] epc,
`endif
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc_plus4,
    output logic [WIDTH-1:0] link_addr,
    output logic             taken,
    output logic             pend_valid
);

    localparam logic [WIDTH-1:0] RESET_PC_W = WIDTH'(RESET_PC);
    localparam logic [WIDTH-1:0] FOUR       = WIDTH'(4);
    localparam logic [WIDTH-1:0] EIGHT      = WIDTH'(8);
`ifdef PC_EXC_EN
    localparam logic [WIDTH-1:0] EXC_PC_W   = WIDTH'(EXC_VECTOR);
`endif

    typedef enum logic [2:0] {
        BR_NONE = 3'b000,
        BR_BEQ  = 3'b001,
        BR_BNE  = 3'b010,
        BR_BLEZ = 3'b011,
        BR_BGTZ = 3'b100,
        BR_BLTZ = 3'b101,
        BR_BGEZ = 3'b110,
        BR_RSVD = 3'b111
    } br_type_e;

    logic [WIDTH-1:0] pend_target;
    logic [WIDTH-1:0] dec_pc_plus4;
    logic [WIDTH-1:0] branch_offset;
    logic [WIDTH-1:0] branch_target;
    logic [WIDTH-1:0] jump_target;
    logic [WIDTH-1:0] target;
    logic             rs_neg;
    logic             rs_zero;
    logic             branch_cond;

    logic [WIDTH-1:0] pc_next;
    logic [WIDTH-1:0] pend_target_next;
    logic             pend_valid_next;

    assign pc_plus4      = pc + FOUR;
    assign link_addr     = dec_pc + EIGHT;
    assign dec_pc_plus4  = dec_pc + FOUR;
    assign branch_offset = {{(WIDTH-18){imm16[15]}}, imm16, 2'b00};
    assign branch_target = dec_pc_plus4 + branch_offset;
    assign jump_target   = {dec_pc_plus4[WIDTH-1:28], imm26, 2'b00};

    // Signed zero compares reduce to the sign bit plus an all-zero test.
    assign rs_neg  = rs_val[WIDTH-1];
    assign rs_zero = (rs_val == '0);

    always_comb begin
        branch_cond = 1'b0;
        unique case (br_type_e'(br_type))
            BR_BEQ:  branch_cond = (rs_val == rt_val);
            BR_BNE:  branch_cond = (rs_val != rt_val);
            BR_BLEZ: branch_cond = rs_neg | rs_zero;
            BR_BGTZ: branch_cond = ~rs_neg & ~rs_zero;
            BR_BLTZ: branch_cond = rs_neg;
            BR_BGEZ: branch_cond = ~rs_neg;
            BR_NONE,
            BR_RSVD: branch_cond = 1'b0;
            default: branch_cond = 1'b0;
        endcase
    end

    assign taken = jump_reg | jump | branch_cond;

    always_comb begin
        target = branch_target;
        if (jump_reg) begin
            target = rs_val;
        end else if (jump) begin
            target = jump_target;
        end
    end

    always_comb begin
        pc_next          = pc;
        pend_valid_next  = pend_valid;
        pend_target_next = pend_target;

        if (fetch_stall) begin
            // Latest redirect wins; an older buffered one is simply replaced.
            if (taken) begin
                pend_target_next = target;
                pend_valid_next  = 1'b1;
            end
        end else if (taken) begin
            pc_next         = target;
            pend_valid_next = 1'b0;
        end else if (pend_valid) begin
            pc_next         = pend_target;
            pend_valid_next = 1'b0;
        end else begin
            pc_next = pc_plus4;
        end

`ifdef PC_EXC_EN
        // Exception entry / return override stall and any redirect.
        if (exc_req) begin
            pc_next         = EXC_PC_W;
            pend_valid_next = 1'b0;
        end else if (eret) begin
            pc_next         = epc;
            pend_valid_next = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc          <= RESET_PC_W;
            pend_valid  <= 1'b0;
            pend_target <= '0;
        end else begin
            pc          <= pc_next;
            pend_valid  <= pend_valid_next;
            pend_target <= pend_target_next;
        end
    end

endmodule

// File: doc/pc_redirect_unit.md
Name: pc_redirect_unit

Overview:
- Parametrised successor to the combinational next-PC logic, for the pipelined MIPS core.
- Owns the fetch PC register and evaluates branch and jump decisions presented by the decode stage.
- Covers a wider branch set: beq/bne/blez/bgtz/bltz/bgez, j/jal, jr/jalr.
- Buffers one redirect that arrives while fetch is stalled, then applies it when fetch resumes.

Parameters:
- WIDTH, 32, PC and operand width; legal range 32..64.
- RESET_PC, 32'h0000_3000, PC value loaded on reset (zero-extended to WIDTH).
- EXC_VECTOR, 32'h0000_4180, exception entry address; used only with PC_EXC_EN.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- fetch_stall  in  1  hold the PC (imem not ready or hazard)
- br_type  in  3  000 none, 001 beq, 010 bne, 011 blez, 100 bgtz, 101 bltz, 110 bgez, 111 reserved (treated as none)
- jump  in  1  j/jal in decode
- jump_reg  in  1  jr/jalr in decode
- dec_pc  in  WIDTH  PC of the decode-stage instruction
- rs_val  in  WIDTH  forwarded rs
- rt_val  in  WIDTH  forwarded rt
- imm16  in  16  branch offset
- imm26  in  26  jump index
- pc  out  WIDTH  current fetch PC (registered)
- pc_plus4  out  WIDTH  pc+4
- link_addr  out  WIDTH  dec_pc+8 (delay-slot link)
- taken  out  1  combinational: decode instruction redirects this cycle
- pend_valid  out  1  a redirect is buffered (registered)

Behaviour:
- Reset (synchronous, highest priority unless PC_EXC_EN overrides as stated): pc=RESET_PC, pend_valid=0, pend_target=0.
- Branch compares are signed, WIDTH-wide:
  - beq: rs==rt; bne: rs!=rt
  - blez: rs<=0; bgtz: rs>0
  - bltz: rs<0; bgez: rs>=0
- Branch target = dec_pc + 4 + (sign-extended imm16 << 2); the add wraps mod 2^WIDTH.
- Jump target = {(dec_pc+4)[WIDTH-1:28], imm26, 2'b00}.
- jump_reg target = rs_val, used unmodified.
- Priority: jump_reg > jump > taken branch. taken = jump_reg | jump | branch condition true.
- Next-PC selection on each clock edge when not in reset:
  - fetch_stall=1, taken=1: pend_target <= target, pend_valid <= 1; pc holds. A newer redirect overwrites an older pending one.
  - fetch_stall=1, taken=0: pc and the pending state hold.
  - fetch_stall=0, taken=1: pc <= target, pend_valid <= 0. A live redirect beats a pending one.
  - fetch_stall=0, taken=0, pend_valid=1: pc <= pend_target, pend_valid <= 0.
  - Otherwise: pc <= pc+4.
- Latency: one cycle from taken to pc update. A buffered redirect is applied on the first unstalled edge.
- pc wraps from all-ones-minus-3 to 0 with no flag.
- Reset asserted mid-stall discards the pending redirect.
- Low two bits of targets are not checked. jr to an unaligned rs_val propagates unchanged.

Optional Feature:
- PC_EXC_EN defined:
  - Adds ports exc_req (in, 1), eret (in, 1), epc (in, WIDTH).
  - exc_req: pc <= EXC_VECTOR next edge, ignoring fetch_stall and taken; pend_valid <= 0.
  - eret (lower priority than exc_req): pc <= epc, same override rules.
  - reset still wins over both.
- PC_EXC_EN undefined: these ports do not exist and the logic is absent.

Test Plan:
- Reset then 3 free cycles -> pc = 0x3000, 0x3004, 0x3008, 0x300C; pend_valid=0.
- beq, dec_pc=0x3010, rs=rt=5, imm16=0xFFFC, no stall -> taken=1, next pc=0x3004, link_addr=0x3018. Same stimulus with rt=6 -> pc+4.
- bltz rs=0xFFFFFFFF, imm16=0x0002, dec_pc=0x3000 -> target 0x300C. bgez with same rs -> not taken.
- fetch_stall=1 for 3 cycles with jr rs=0x4000 in cycle 1 and jal imm26=0x0000100 in cycle 2 -> pend_valid=1, pc held; on unstall pc=0x0000_0400 (jal overwrote jr), pend_valid=0.
- Pending redirect to 0x5000, reset asserted while stalled -> next pc=0x3000, pend_valid=0.
- PC_EXC_EN: exc_req during fetch_stall with pending redirect -> pc=0x4180, pend_valid=0. eret epc=0x3020 -> pc=0x3020.
